// File: rtl/ifc_pkg.sv
`default_nettype none
// ============================================================================
// Module : ifc_pkg
// Brief  : Shared types and constants for the instruction-fetch controller.
// Rev    : 1.0  initial release
// ============================================================================
package ifc_pkg;

  localparam int AW   = 8;
  localparam int OPW  = 7;
  localparam int LITW = 8;
  localparam int IW   = OPW + LITW;

  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 8;
  localparam int LIT_MSB = 7;
  localparam int LIT_LSB = 0;

  localparam logic [OPW-1:0] HALT_OPCODE = 7'h7F;
  localparam logic [AW-1:0]  RESET_PC    = 8'h00;

  typedef enum logic [1:0] {
    CTL_RUN    = 2'd0,
    CTL_HALTED = 2'd1,
    CTL_LOAD   = 2'd2
  } ctl_state_t;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_HI   = 2'd1,
    LD_LO   = 2'd2,
    LD_WR   = 2'd3
  } ld_state_t;

  function automatic logic [OPW-1:0] im_opcode(input logic [IW-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage : ifc_pkg
`default_nettype wire

// File: rtl/im_stream_loader.sv
`default_nettype none
// ============================================================================
// Module : im_stream_loader
// Brief  : Pairs a valid/ready byte stream into 15-bit IM words and writes them.
// Rev    : 1.0  initial release
// ============================================================================
module im_stream_loader
  import ifc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_start,
  input  logic [AW-1:0]   load_last,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            im_we,
  output logic [AW-1:0]   im_waddr,
  output logic [IW-1:0]   im_wdata,
  output logic            load_err,
  output logic            core_hold,
  output logic            load_done
);

  ld_state_t         st_q;
  logic [AW-1:0]     wcnt_q;
  logic [AW-1:0]     last_q;
  logic [OPW-1:0]    hi_q;
  logic              we_q;
  logic [AW-1:0]     waddr_q;
  logic [IW-1:0]     wdata_q;
  logic              err_q;
  logic              hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= LD_IDLE;
      wcnt_q  <= '0;
      last_q  <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // A restart drops any half-assembled word; earlier writes are kept.
      if (load_start) begin
        st_q   <= LD_HI;
        last_q <= load_last;
        wcnt_q <= '0;
        err_q  <= 1'b0;
        hold_q <= 1'b1;
      end else begin
        case (st_q)
          LD_HI: begin
            if (in_valid) begin
              hi_q <= in_data[OPW-1:0];
              if (in_data[7]) err_q <= 1'b1;
              st_q <= LD_LO;
            end
          end
          LD_LO: begin
            if (in_valid) begin
              wdata_q <= {hi_q, in_data};
              waddr_q <= wcnt_q;
              we_q    <= 1'b1;
              st_q    <= LD_WR;
            end
          end
          LD_WR: begin
            if (wcnt_q == last_q) begin
              st_q   <= LD_IDLE;
              hold_q <= 1'b0;
            end else begin
              wcnt_q <= wcnt_q + AW'(1);
              st_q   <= LD_HI;
            end
          end
          default: st_q <= LD_IDLE;
        endcase
      end
    end
  end

  assign in_ready  = (st_q == LD_HI) || (st_q == LD_LO);
  assign im_we     = we_q;
  assign im_waddr  = waddr_q;
  assign im_wdata  = wdata_q;
  assign load_err  = err_q;
  assign core_hold = hold_q;
  assign load_done = (st_q == LD_WR) && (wcnt_q == last_q);

endmodule : im_stream_loader
`default_nettype wire

// File: rtl/im_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : im_fetch_ctrl
// Brief  : Program counter / fetch sequencer with run-time IM reload.
// Rev    : 1.0  initial release
// ============================================================================
module im_fetch_ctrl
  import ifc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            jump_en,
  input  logic [AW-1:0]   jump_addr,
  input  logic            resume,
  input  logic [IW-1:0]   im_rdata,
  output logic [AW-1:0]   im_addr,
  output logic            instr_valid,
  output logic            halted,
  output logic            core_hold,
  input  logic            load_start,
  input  logic [AW-1:0]   load_last,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            im_we,
  output logic [AW-1:0]   im_waddr,
  output logic [IW-1:0]   im_wdata,
  output logic            load_err
);

  ctl_state_t      state_q;
  logic [AW-1:0]   pc_q;
  logic            halted_q;

  logic            w_halt_hit;
  logic [AW-1:0]   w_pc_inc;
  logic            w_ld_done;

  assign w_halt_hit = (im_opcode(im_rdata) == HALT_OPCODE);
  assign w_pc_inc   = pc_q + AW'(1);

  im_stream_loader u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_last  (load_last),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .load_err   (load_err),
    .core_hold  (core_hold),
    .load_done  (w_ld_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CTL_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (load_start) begin
      state_q  <= CTL_LOAD;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        CTL_RUN: begin
          // Jump beats stall; a HALT word only takes effect when fetch would advance.
          if (jump_en) begin
            pc_q <= jump_addr;
          end else if (!stall) begin
            if (w_halt_hit) begin
              state_q  <= CTL_HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= w_pc_inc;
            end
          end
        end
        CTL_HALTED: begin
          if (resume) begin
            pc_q     <= w_pc_inc;
            state_q  <= CTL_RUN;
            halted_q <= 1'b0;
          end else if (jump_en) begin
            pc_q     <= jump_addr;
            state_q  <= CTL_RUN;
            halted_q <= 1'b0;
          end
        end
        CTL_LOAD: begin
          if (w_ld_done) begin
            pc_q    <= RESET_PC;
            state_q <= CTL_RUN;
          end
        end
        default: state_q <= CTL_RUN;
      endcase
    end
  end

  assign im_addr     = pc_q;
  assign instr_valid = (state_q == CTL_RUN) && !stall;
  assign halted      = halted_q;

endmodule : im_fetch_ctrl
`default_nettype wire

// File: tb/tb_im_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_im_fetch_ctrl
// Brief  : Self-checking bench for im_fetch_ctrl with a behavioural IM and PC model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_im_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump_en, resume;
  logic [7:0]  jump_addr;
  logic [14:0] im_rdata;
  logic [7:0]  im_addr;
  logic        instr_valid, halted, core_hold;
  logic        load_start;
  logic [7:0]  load_last;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready, im_we, load_err;
  logic [7:0]  im_waddr;
  logic [14:0] im_wdata;

  logic [14:0] tb_mem [256];
  logic [22:0] wq [$];
  int          n_run  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign im_rdata = tb_mem[im_addr];

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      tb_mem[im_waddr] = im_wdata;
      wq.push_back({im_waddr, im_wdata});
    end
  end

  im_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr),
    .resume(resume), .im_rdata(im_rdata), .im_addr(im_addr), .instr_valid(instr_valid),
    .halted(halted), .core_hold(core_hold), .load_start(load_start), .load_last(load_last),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .im_we(im_we),
    .im_waddr(im_waddr), .im_wdata(im_wdata), .load_err(load_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] last);
    load_start = 1'b1;
    load_last  = last;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) step();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    n_run++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL send_byte: in_ready never high for byte %h", b);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (core_hold && n < 50) begin
      step();
      n++;
    end
    n_run++;
    if (core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done: core_hold=%b after %0d cycles, want 0", core_hold, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; jump_en = 0; resume = 0; jump_addr = 0;
    load_start = 0; load_last = 0; in_valid = 0; in_data = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 15'h0100;
    repeat (3) step();
    n_run += 8;
    if (im_addr !== 8'h00)    begin n_fail++; $display("FAIL rst_pc: got %h want 00", im_addr); end
    if (halted !== 1'b0)      begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    if (core_hold !== 1'b0)   begin n_fail++; $display("FAIL rst_hold: got %b want 0", core_hold); end
    if (im_we !== 1'b0)       begin n_fail++; $display("FAIL rst_we: got %b want 0", im_we); end
    if (im_waddr !== 8'h00)   begin n_fail++; $display("FAIL rst_waddr: got %h want 00", im_waddr); end
    if (im_wdata !== 15'h0)   begin n_fail++; $display("FAIL rst_wdata: got %h want 0", im_wdata); end
    if (load_err !== 1'b0)    begin n_fail++; $display("FAIL rst_err: got %b want 0", load_err); end
    if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL rst_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_sequential();
    logic [7:0] ep;
    ep = 8'h00;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 300; i++) begin
      n_run += 2;
      if (im_addr !== ep) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, im_addr, ep); end
      if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); end
      step();
      ep = ep + 8'd1;
    end
  endtask

  task automatic test_stall();
    jump_en = 1; jump_addr = 8'h05;
    step();
    jump_en = 0;
    stall = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_run += 2;
      if (im_addr !== 8'h05) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 05", i, im_addr); end
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 0", i, instr_valid); end
      step();
    end
    n_run++;
    if (im_addr !== 8'h05) begin n_fail++; $display("FAIL stall_hold: got %h want 05", im_addr); end
    jump_en = 1; jump_addr = 8'h40;
    step();
    jump_en = 0; stall = 0;
    n_run++;
    if (im_addr !== 8'h40) begin n_fail++; $display("FAIL stall_jump: got %h want 40", im_addr); end
  endtask

  task automatic test_halt();
    tb_mem[3] = 15'h7F00;
    jump_en = 1; jump_addr = 8'h00;
    step();
    jump_en = 0;
    repeat (4) step();
    for (int i = 0; i < 2; i++) begin
      n_run += 3;
      if (im_addr !== 8'h03) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h want 03", i, im_addr); end
      if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag[%0d]: got %b want 1", i, halted); end
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d]: got %b want 0", i, instr_valid); end
      step();
    end
    resume = 1;
    step();
    resume = 0;
    n_run += 3;
    if (im_addr !== 8'h04) begin n_fail++; $display("FAIL resume_pc: got %h want 04", im_addr); end
    if (halted !== 1'b0) begin n_fail++; $display("FAIL resume_flag: got %b want 0", halted); end
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid: got %b want 1", instr_valid); end
    tb_mem[3] = 15'h0100;
  endtask

  task automatic test_load();
    wq.delete();
    start_load(8'd1);
    n_run += 3;
    if (core_hold !== 1'b1) begin n_fail++; $display("FAIL load_hold: got %b want 1", core_hold); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", in_ready); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL load_valid: got %b want 0", instr_valid); end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h05); send_byte(8'h67);
    wait_done();
    n_run += 4;
    if (im_addr !== 8'h00) begin n_fail++; $display("FAIL load_pc: got %h want 00", im_addr); end
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL load_run: got %b want 1", instr_valid); end
    if (wq.size() != 2) begin n_fail++; $display("FAIL load_count: got %0d writes want 2", wq.size()); end
    else begin
      if (wq[0] !== {8'h00, 15'h1234}) begin n_fail++; $display("FAIL load_w0: got %h want %h", wq[0], {8'h00, 15'h1234}); end
    end
    if (wq.size() >= 2 && wq[1] !== {8'h01, 15'h0567}) begin
      n_fail++; $display("FAIL load_w1: got %h want %h", wq[1], {8'h01, 15'h0567});
    end
  endtask

  task automatic test_load_err();
    wq.delete();
    start_load(8'd0);
    send_byte(8'h92);
    n_run++;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", load_err); end
    send_byte(8'hAB);
    wait_done();
    n_run += 2;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", load_err); end
    if (wq.size() != 1 || wq[0] !== {8'h00, 15'h12AB}) begin
      n_fail++; $display("FAIL err_word: got %0d writes, first %h want %h", wq.size(), (wq.size() > 0) ? wq[0] : 23'h0, {8'h00, 15'h12AB});
    end
    start_load(8'd0);
    n_run++;
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", load_err); end
    send_byte(8'h01); send_byte(8'h00);
    wait_done();
  endtask

  task automatic test_abort();
    wq.delete();
    start_load(8'd3);
    send_byte(8'h11);
    start_load(8'd0);
    n_run += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    if (wq.size() != 0) begin n_fail++; $display("FAIL abort_nowrite: got %0d writes want 0", wq.size()); end
    send_byte(8'h02); send_byte(8'h22);
    wait_done();
    n_run++;
    if (wq.size() != 1 || wq[0] !== {8'h00, 15'h0222}) begin
      n_fail++; $display("FAIL abort_word: got %0d writes, first %h want %h", wq.size(), (wq.size() > 0) ? wq[0] : 23'h0, {8'h00, 15'h0222});
    end
  endtask

  task automatic test_random_load();
    logic [22:0] exp_w [$];
    logic [7:0]  hb, lb;
    logic        eerr;
    int          nw;
    for (int k = 0; k < 4; k++) begin
      wq.delete(); exp_w.delete(); eerr = 1'b0;
      nw = $urandom_range(1, 4);
      start_load(8'(nw - 1));
      for (int w = 0; w < nw; w++) begin
        hb = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 8'h7E))};
        lb = 8'($urandom);
        eerr = eerr | hb[7];
        exp_w.push_back({8'(w), hb[6:0], lb});
        send_byte(hb); send_byte(lb);
      end
      wait_done();
      n_run += 3;
      if (load_err !== eerr) begin n_fail++; $display("FAIL rload_err[%0d]: got %b want %b", k, load_err, eerr); end
      if (im_addr !== 8'h00) begin n_fail++; $display("FAIL rload_pc[%0d]: got %h want 00", k, im_addr); end
      if (wq.size() != exp_w.size()) begin
        n_fail++; $display("FAIL rload_count[%0d]: got %0d want %0d", k, wq.size(), exp_w.size());
      end else begin
        for (int w = 0; w < nw; w++) begin
          n_run++;
          if (wq[w] !== exp_w[w]) begin n_fail++; $display("FAIL rload_w[%0d][%0d]: got %h want %h", k, w, wq[w], exp_w[w]); end
        end
      end
    end
  endtask

  task automatic test_random_run();
    logic [7:0] ep;
    logic       eh;
    for (int i = 0; i < 4; i++) tb_mem[8'h80 + 8'($urandom_range(0, 127))] = 15'h7F00;
    jump_en = 1; jump_addr = 8'h10;
    step();
    jump_en = 0;
    ep = 8'h10; eh = 1'b0;
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      stall     = ($urandom_range(0, 3) == 0);
      jump_en   = (r == 0);
      resume    = (r >= 1 && r <= 3);
      jump_addr = (r == 0) ? (($urandom_range(0, 1) == 1) ? 8'h80 + 8'($urandom_range(0, 127)) : 8'($urandom)) : 8'h00;
      #1;
      n_run += 3;
      if (im_addr !== ep) begin n_fail++; $display("FAIL rrun_pc[%0d]: got %h want %h", i, im_addr, ep); end
      if (halted !== eh) begin n_fail++; $display("FAIL rrun_halt[%0d]: got %b want %b", i, halted, eh); end
      if (instr_valid !== (!eh && !stall)) begin
        n_fail++; $display("FAIL rrun_valid[%0d]: got %b want %b", i, instr_valid, (!eh && !stall));
      end
      if (!eh) begin
        if (jump_en) ep = jump_addr;
        else if (!stall) begin
          if (tb_mem[ep][14:8] == 7'h7F) eh = 1'b1;
          else ep = ep + 8'd1;
        end
      end else begin
        if (resume) begin ep = ep + 8'd1; eh = 1'b0; end
        else if (jump_en) begin ep = jump_addr; eh = 1'b0; end
      end
      @(posedge clk);
      #1;
    end
    stall = 0; jump_en = 0; resume = 0;
  endtask

  task automatic test_reset_midload();
    start_load(8'd2);
    send_byte(8'h33);
    #2 rst_n = 1'b0;
    #1;
    n_run += 6;
    if (im_addr !== 8'h00) begin n_fail++; $display("FAIL mrst_pc: got %h want 00", im_addr); end
    if (im_we !== 1'b0) begin n_fail++; $display("FAIL mrst_we: got %b want 0", im_we); end
    if (core_hold !== 1'b0) begin n_fail++; $display("FAIL mrst_hold: got %b want 0", core_hold); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_ready: got %b want 0", in_ready); end
    if (halted !== 1'b0) begin n_fail++; $display("FAIL mrst_halted: got %b want 0", halted); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL mrst_err: got %b want 0", load_err); end
    step();
    rst_n = 1'b1;
    #1;
    n_run++;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_run: got %b want 1", instr_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_halt();
    test_load();
    test_load_err();
    test_abort();
    test_random_load();
    test_random_run();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_im_fetch_ctrl
`default_nettype wire
